run_checker: RTL and testbench

RUN_CHECKER -- requirements
Module: run_checker

---
 rtl/run_checker_pkg.sv | 27 ++
 rtl/run_watchdog.sv | 34 +++
 rtl/run_checker.sv | 182 ++++++++++++++++++
 tb/tb_run_checker.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_checker_pkg.sv
// Shared types and default widths for the run_checker block.
// Holds the controller state encoding, the result code encoding and the
// default parameter values used by run_checker and run_watchdog.
package run_checker_pkg;

   localparam int unsigned DEF_DATA_W   = 8;
   localparam int unsigned DEF_ADDR_W   = 16;
   localparam int unsigned DEF_NUM_REGS = 4;
   localparam int unsigned DEF_FLAG_W   = 5;
   localparam int unsigned DEF_CNT_W    = 20;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      FC_OK       = 2'd0,
      FC_TIMEOUT  = 2'd1,
      FC_MISMATCH = 2'd2,
      FC_LOAD_OVF = 2'd3
   } fail_code_t;

endpackage

// File: rtl/run_watchdog.sv
// Run cycle counter with watchdog compare.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   en_i           count enable; counter is held at zero while low
//   timeout_i      watchdog limit, 0 disables the watchdog
//   count_o        current cycle count, saturates at all-ones
//   expired_o      combinational: enabled, limit nonzero and count == limit
module run_watchdog
   import run_checker_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] timeout_i,
   output logic [CNT_W-1:0] count_o,
   output logic             expired_o
);

   // Counter restarts from zero each time the enable window opens
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_o <= '0;
      end else if (!en_i) begin
         count_o <= '0;
      end else if (count_o != '1) begin
         count_o <= count_o + CNT_W'(1);
      end
   end

   assign expired_o = en_i && (timeout_i != '0) && (count_o == timeout_i);

endmodule

// File: rtl/run_checker.sv
// Program-load / run / result-check controller for a small test core.
// Streams a program image into core memory, releases the core from reset,
// waits for halt (optionally bounded by a watchdog), then compares the core
// register file and flags against expected values.
// Optional feature: define RUN_CHECKER_WDOG_EN to add timeout_i and the
// run watchdog; without it RUN waits for halt indefinitely.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   start_i                            start request (ignored while busy_o)
//   ld_valid_i/ld_ready_o/ld_data_i/ld_last_i   program byte stream
//   mem_we_o/mem_addr_o/mem_wdata_o    program memory write port
//   core_rst_o, core_halt_i            core reset control, halt status
//   rf_idx_o, rf_data_i                register read (data valid same cycle)
//   flags_i/exp_flags_i/flag_mask_i    actual, expected flags and compare mask
//   exp_regs_i                         expected registers, entry 0 in LSBs
//   timeout_i                          watchdog limit (RUN_CHECKER_WDOG_EN only)
//   busy_o, done_o, pass_o, fail_code_o, mism_idx_o, cycles_o   status
module run_checker
   import run_checker_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned FLAG_W   = DEF_FLAG_W,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 start_i,
   input  logic                                 ld_valid_i,
   output logic                                 ld_ready_o,
   input  logic [DATA_W-1:0]                    ld_data_i,
   input  logic                                 ld_last_i,
   output logic                                 mem_we_o,
   output logic [ADDR_W-1:0]                    mem_addr_o,
   output logic [DATA_W-1:0]                    mem_wdata_o,
   output logic                                 core_rst_o,
   input  logic                                 core_halt_i,
   output logic [$clog2(NUM_REGS)-1:0]          rf_idx_o,
   input  logic [DATA_W-1:0]                    rf_data_i,
   input  logic [FLAG_W-1:0]                    flags_i,
   input  logic [FLAG_W-1:0]                    exp_flags_i,
   input  logic [FLAG_W-1:0]                    flag_mask_i,
   input  logic [NUM_REGS*DATA_W-1:0]           exp_regs_i,
`ifdef RUN_CHECKER_WDOG_EN
   input  logic [CNT_W-1:0]                     timeout_i,
`endif
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 pass_o,
   output logic [1:0]                           fail_code_o,
   output logic [$clog2(NUM_REGS+1)-1:0]        mism_idx_o,
   output logic [CNT_W-1:0]                     cycles_o
);

   localparam int unsigned IDX_W  = $clog2(NUM_REGS + 1);
   localparam int unsigned RIDX_W = $clog2(NUM_REGS);

   state_t            state;
   fail_code_t        fail_q;
   logic [ADDR_W-1:0] addr;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  wd_count;
   logic              wd_expired;
   logic [CNT_W-1:0]  wd_limit;
   logic [DATA_W-1:0] exp_arr [NUM_REGS];
   logic              reg_ok;
   logic              flags_ok;

`ifdef RUN_CHECKER_WDOG_EN
   assign wd_limit = timeout_i;
`else
   assign wd_limit = '0;
`endif

   run_watchdog #(
      .CNT_W (CNT_W)
   ) u_wdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (state == ST_RUN),
      .timeout_i (wd_limit),
      .count_o   (wd_count),
      .expired_o (wd_expired)
   );

   // Unpack expected register vector for indexed compare
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_exp
      assign exp_arr[g] = exp_regs_i[g*DATA_W +: DATA_W];
   end

   // Status decodes of the state register
   assign busy_o      = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_CHECK);
   assign core_rst_o  = !((state == ST_RUN) || (state == ST_CHECK));
   assign ld_ready_o  = (state == ST_LOAD);
   assign mem_we_o    = ld_valid_i && ld_ready_o;
   assign mem_addr_o  = addr;
   assign mem_wdata_o = ld_data_i;
   assign rf_idx_o    = RIDX_W'(idx);
   assign fail_code_o = fail_q;

   assign reg_ok   = (rf_data_i == exp_arr[rf_idx_o]);
   assign flags_ok = (((flags_i ^ exp_flags_i) & flag_mask_i) == '0);

   // Controller: load -> run -> check, results held in DONE
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         fail_q     <= FC_OK;
         addr       <= '0;
         idx        <= '0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         mism_idx_o <= '0;
         cycles_o   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state      <= ST_LOAD;
                  addr       <= '0;
                  done_o     <= 1'b0;
                  pass_o     <= 1'b0;
                  fail_q     <= FC_OK;
                  mism_idx_o <= '0;
                  cycles_o   <= '0;
               end
            end
            ST_LOAD: begin
               if (ld_valid_i) begin
                  if (ld_last_i) begin
                     state <= ST_RUN;
                     addr  <= addr + ADDR_W'(1);
                  end else if (addr == '1) begin
                     // Image larger than memory: stop rather than wrap
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                     fail_q <= FC_LOAD_OVF;
                  end else begin
                     addr <= addr + ADDR_W'(1);
                  end
               end
            end
            ST_RUN: begin
               // Halt takes priority over a watchdog hit in the same cycle
               if (core_halt_i) begin
                  state    <= ST_CHECK;
                  idx      <= '0;
                  cycles_o <= wd_count;
               end else if (wd_expired) begin
                  state    <= ST_DONE;
                  done_o   <= 1'b1;
                  fail_q   <= FC_TIMEOUT;
                  cycles_o <= wd_count;
               end
            end
            ST_CHECK: begin
               if (idx == IDX_W'(NUM_REGS)) begin
                  state  <= ST_DONE;
                  done_o <= 1'b1;
                  if (flags_ok) begin
                     pass_o <= 1'b1;
                     fail_q <= FC_OK;
                  end else begin
                     fail_q     <= FC_MISMATCH;
                     mism_idx_o <= idx;
                  end
               end else if (!reg_ok) begin
                  state      <= ST_DONE;
                  done_o     <= 1'b1;
                  fail_q     <= FC_MISMATCH;
                  mism_idx_o <= idx;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_run_checker.sv
// Directed self-checking bench for run_checker (ADDR_W=4 instance so the
// load-overflow case is reachable in a short run).
module tb_run_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ld_valid;
   logic        ld_ready;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        core_rst;
   logic        halt;
   logic [1:0]  rf_idx;
   logic [7:0]  rf_data;
   logic [4:0]  flags;
   logic [4:0]  exp_flags;
   logic [4:0]  mask;
   logic [31:0] exp_regs;
`ifdef RUN_CHECKER_WDOG_EN
   logic [19:0] timeout;
`endif
   logic        busy;
   logic        done;
   logic        pass;
   logic [1:0]  fail_code;
   logic [2:0]  mism_idx;
   logic [19:0] cycles;

   logic [7:0]  rf_model [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Behavioural core register file: combinational read
   always_comb rf_data = rf_model[rf_idx];

   run_checker #(
      .DATA_W   (8),
      .ADDR_W   (4),
      .NUM_REGS (4),
      .FLAG_W   (5),
      .CNT_W    (20)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .ld_valid_i  (ld_valid),
      .ld_ready_o  (ld_ready),
      .ld_data_i   (ld_data),
      .ld_last_i   (ld_last),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .core_rst_o  (core_rst),
      .core_halt_i (halt),
      .rf_idx_o    (rf_idx),
      .rf_data_i   (rf_data),
      .flags_i     (flags),
      .exp_flags_i (exp_flags),
      .flag_mask_i (mask),
      .exp_regs_i  (exp_regs),
`ifdef RUN_CHECKER_WDOG_EN
      .timeout_i   (timeout),
`endif
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .fail_code_o (fail_code),
      .mism_idx_o  (mism_idx),
      .cycles_o    (cycles)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_bytes(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = 8'(8'hA0 + i);
         ld_last  = with_last && (i == n - 1);
         tick();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   // Returns the number of edges until done_o, or -1 after 50 edges
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_to_done(input int halt_delay, output int lat);
      do_start();
      load_bytes(3, 1'b1);
      repeat (halt_delay) tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      wait_done(lat);
   endtask

   task automatic set_match_regs();
      rf_model[0] = 8'h10;
      rf_model[1] = 8'h02;
      rf_model[2] = 8'h00;
      rf_model[3] = 8'h00;
      exp_regs    = {8'h00, 8'h00, 8'h02, 8'h10};
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      ld_valid = 1'b1;
      #2;
      checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      checks++; if (fail_code !== 2'd0 || cycles !== 20'd0 || pass !== 1'b0) begin
         errors++; $display("FAIL reset_status got fc=%0d cyc=%0d pass=%b exp 0/0/0", fail_code, cycles, pass);
      end
      ld_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load();
      int lat;
      do_start();
      checks++; if (ld_ready !== 1'b1 || busy !== 1'b1 || core_rst !== 1'b1) begin
         errors++; $display("FAIL load_entry got rdy=%b busy=%b crst=%b exp 1/1/1", ld_ready, busy, core_rst);
      end
      ld_valid = 1'b1;
      ld_data  = 8'h5A;
      #1;
      checks++; if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 8'h5A) begin
         errors++; $display("FAIL load_beat0 got we=%b a=%0d d=%h exp 1/0/5a", mem_we, mem_addr, mem_wdata);
      end
      tick();
      ld_valid = 1'b0;
      start    = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_idle_we got=%b exp=0", mem_we); end
      tick();
      start = 1'b0;
      checks++; if (mem_addr !== 4'd1 || ld_ready !== 1'b1) begin
         errors++; $display("FAIL load_start_ignored got a=%0d rdy=%b exp 1/1", mem_addr, ld_ready);
      end
      load_bytes(2, 1'b1);
      checks++; if (core_rst !== 1'b0 || ld_ready !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL load_to_run got crst=%b rdy=%b busy=%b exp 0/0/1", core_rst, ld_ready, busy);
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      wait_done(lat);
      checks++; if (lat < 0) begin errors++; $display("FAIL load_finish got=timeout exp=done"); end
   endtask

   task automatic test_pass();
      int lat;
      set_match_regs();
      flags     = 5'b00010;
      exp_flags = 5'b00010;
      mask      = 5'b00011;
      run_to_done(10, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL pass_latency got=%0d exp=5", lat); end
      checks++; if (pass !== 1'b1 || fail_code !== 2'd0) begin
         errors++; $display("FAIL pass_result got pass=%b fc=%0d exp 1/0", pass, fail_code);
      end
      checks++; if (cycles !== 20'd10) begin errors++; $display("FAIL pass_cycles got=%0d exp=10", cycles); end
      repeat (3) tick();
      checks++; if (done !== 1'b1 || pass !== 1'b1 || cycles !== 20'd10 || core_rst !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL pass_hold got done=%b pass=%b cyc=%0d crst=%b busy=%b exp 1/1/10/1/0",
                            done, pass, cycles, core_rst, busy);
      end
   endtask

   task automatic test_reg_mismatch();
      int lat;
      set_match_regs();
      rf_model[1] = 8'h03;
      run_to_done(4, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL regmm_latency got=%0d exp=2", lat); end
      checks++; if (fail_code !== 2'd2 || mism_idx !== 3'd1 || pass !== 1'b0) begin
         errors++; $display("FAIL regmm_result got fc=%0d idx=%0d pass=%b exp 2/1/0", fail_code, mism_idx, pass);
      end
      checks++; if (cycles !== 20'd4) begin errors++; $display("FAIL regmm_cycles got=%0d exp=4", cycles); end
   endtask

   task automatic test_flags();
      int lat;
      set_match_regs();
      flags     = 5'b00001;
      exp_flags = 5'b00000;
      mask      = 5'b00001;
      run_to_done(0, lat);
      checks++; if (lat !== 5 || fail_code !== 2'd2 || mism_idx !== 3'd4) begin
         errors++; $display("FAIL flagmm_result got lat=%0d fc=%0d idx=%0d exp 5/2/4", lat, fail_code, mism_idx);
      end
      mask = 5'b00000;
      do_start();
      checks++; if (done !== 1'b0 || fail_code !== 2'd0 || mism_idx !== 3'd0) begin
         errors++; $display("FAIL restart_clear got done=%b fc=%0d idx=%0d exp 0/0/0", done, fail_code, mism_idx);
      end
      load_bytes(3, 1'b1);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      wait_done(lat);
      checks++; if (pass !== 1'b1 || fail_code !== 2'd0 || lat !== 5) begin
         errors++; $display("FAIL flagmask_pass got pass=%b fc=%0d lat=%0d exp 1/0/5", pass, fail_code, lat);
      end
   endtask

   task automatic test_overflow();
      int writes = 0;
      int addr_err = 0;
      do_start();
      for (int i = 0; i < 17; i++) begin
         ld_valid = 1'b1;
         ld_data  = 8'(i);
         ld_last  = 1'b0;
         #1;
         if (mem_we) begin
            writes++;
            if (mem_addr !== 4'(i)) addr_err++;
         end
         tick();
      end
      ld_valid = 1'b0;
      checks++; if (writes !== 16 || addr_err !== 0) begin
         errors++; $display("FAIL ovf_writes got=%0d addr_err=%0d exp 16/0", writes, addr_err);
      end
      checks++; if (fail_code !== 2'd3 || done !== 1'b1 || ld_ready !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL ovf_result got fc=%0d done=%b rdy=%b busy=%b exp 3/1/0/0",
                            fail_code, done, ld_ready, busy);
      end
   endtask

`ifdef RUN_CHECKER_WDOG_EN
   task automatic test_watchdog();
      timeout = 20'd50;
      do_start();
      load_bytes(3, 1'b1);
      repeat (50) tick();
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL wdog_early got done=%b busy=%b exp 0/1", done, busy);
      end
      tick();
      checks++; if (done !== 1'b1 || fail_code !== 2'd1 || pass !== 1'b0) begin
         errors++; $display("FAIL wdog_fire got done=%b fc=%0d pass=%b exp 1/1/0", done, fail_code, pass);
      end
      timeout = 20'd0;
   endtask
`endif

   // Leaves the DUT in RUN for the mid-run reset scenario
   task automatic test_no_timeout();
      do_start();
      load_bytes(3, 1'b1);
      repeat (1000) tick();
      checks++; if (done !== 1'b0 || busy !== 1'b1 || core_rst !== 1'b0) begin
         errors++; $display("FAIL long_run got done=%b busy=%b crst=%b exp 0/1/0", done, busy, core_rst);
      end
   endtask

   task automatic test_reset_mid_run();
      rst = 1'b1;
      #2;
      checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL midrst got crst=%b busy=%b done=%b exp 1/0/0", core_rst, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL midrst_idle got busy=%b done=%b exp 0/0", busy, done);
      end
      do_start();
      checks++; if (ld_ready !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL midrst_restart got rdy=%b busy=%b exp 1/1", ld_ready, busy);
      end
   endtask

   initial begin
      start     = 1'b0;
      ld_valid  = 1'b0;
      ld_data   = 8'h00;
      ld_last   = 1'b0;
      halt      = 1'b0;
      flags     = 5'b0;
      exp_flags = 5'b0;
      mask      = 5'b0;
      set_match_regs();
`ifdef RUN_CHECKER_WDOG_EN
      timeout   = 20'd0;
`endif
      test_reset();
      test_load();
      test_pass();
      test_reg_mismatch();
      test_flags();
      test_overflow();
`ifdef RUN_CHECKER_WDOG_EN
      test_watchdog();
`endif
      test_no_timeout();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
